// File: rtl/tff_pkg.sv
// tff_pkg: shared mode encodings for the T flip-flop bank counter.
package tff_pkg;
   localparam logic [1:0] MODE_HOLD       = 2'b00;
   localparam logic [1:0] MODE_TOGGLE     = 2'b01;
   localparam logic [1:0] MODE_COUNT_UP   = 2'b10;
   localparam logic [1:0] MODE_COUNT_DOWN = 2'b11;
   typedef enum logic [1:0] {
      HOLD       = MODE_HOLD,
      TOGGLE     = MODE_TOGGLE,
      COUNT_UP   = MODE_COUNT_UP,
      COUNT_DOWN = MODE_COUNT_DOWN
   } mode_e;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single-bit T flip-flop with synchronous reset and parallel load.
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic rst_val,
   input  logic ld,
   input  logic d,
   input  logic tog,
   output logic q
);
   always_ff @(posedge clk)
      if (reset) q <= rst_val;
      else if (ld) q <= d;
      else if (tog) q <= ~q;
endmodule

// File: rtl/tff_bank_counter.sv
// tff_bank_counter: bank of T flip-flops usable as independent toggles or an
// up/down toggle-chain counter with load, wrap/saturate and a terminal-count pulse.
module tff_bank_counter
   import tff_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               SATURATE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic             tc
);
   mode_e            m;
   logic [WIDTH-1:0] ones, zeros, tog;
   logic             lim;
   assign m = mode_e'(mode);
   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_cell
         // Prefix chain: a cell toggles once every lower cell sits at the carry/borrow value.
         if (g == 0) begin : g_lsb
            assign ones[g]  = 1'b1;
            assign zeros[g] = 1'b1;
         end else begin : g_up
            assign ones[g]  = &q[g-1:0];
            assign zeros[g] = ~|q[g-1:0];
         end
         tff_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .rst_val(RESET_VAL[g]),
            .ld     (load),
            .d      (load_val[g]),
            .tog    (tog[g]),
            .q      (q[g])
         );
      end
   endgenerate
   always_comb begin
      lim = (m == COUNT_UP && &q) || (m == COUNT_DOWN && ~|q);
      tog = !en                    ? '0    :
            m == TOGGLE            ? t     :
            (SATURATE != 0 && lim) ? '0    :
            m == COUNT_UP          ? ones  :
            m == COUNT_DOWN        ? zeros : '0;
   end
   always_ff @(posedge clk)
      if (reset || load) tc <= 1'b0;
      else tc <= en && lim;
endmodule

// File: tb/tb_tff_bank_counter.sv
// tb_tff_bank_counter: directed vectors on a wrapping and a saturating bank,
// expectations queued by the driver and checked by an independent monitor.
module tb_tff_bank_counter;
   import tff_pkg::*;
   typedef struct {
      string      nm;
      logic [3:0] q0, q1;
      logic       tc0, tc1;
   } exp_t;
   logic       clk = 0, reset = 0, en = 0, load = 0;
   logic [3:0] load_val = '0, t = '0, q0, q1;
   logic [1:0] mode = MODE_HOLD;
   logic       tc0, tc1;
   exp_t       sb[$];
   int         n_chk = 0, n_pass = 0;
   bit         done = 0;

   tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'hA), .SATURATE(0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .mode(mode), .t(t), .q(q0), .tc(tc0));
   tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'hA), .SATURATE(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .mode(mode), .t(t), .q(q1), .tc(tc1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   // One call is one clock edge; expectations describe the state just after it.
   task automatic step(input string nm, input logic r, input logic ld, input logic [3:0] lv,
                       input logic e, input logic [1:0] md, input logic [3:0] tt,
                       input logic [3:0] eq0, input logic etc0,
                       input logic [3:0] eq1, input logic etc1);
      exp_t x;
      @(negedge clk);
      reset = r; load = ld; load_val = lv; en = e; mode = md; t = tt;
      x.nm = nm; x.q0 = eq0; x.tc0 = etc0; x.q1 = eq1; x.tc1 = etc1;
      sb.push_back(x);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk({x.nm, ".q_wrap"},  q0,        x.q0);
         chk({x.nm, ".tc_wrap"}, {3'b0, tc0}, {3'b0, x.tc0});
         chk({x.nm, ".q_sat"},   q1,        x.q1);
         chk({x.nm, ".tc_sat"},  {3'b0, tc1}, {3'b0, x.tc1});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      //     name        rst ld lv    en mode             t      q0    tc0  q1    tc1
      step("rst1",      1, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'hA, 0, 4'hA, 0);
      step("rst2",      1, 1, 4'h3, 1, MODE_COUNT_UP,   4'h0, 4'hA, 0, 4'hA, 0);
      for (int i = 0; i < 3; i++)
         step("hold",   0, 0, 4'h0, 1, MODE_HOLD,       4'hF, 4'hA, 0, 4'hA, 0);
      step("ld0",       0, 1, 4'h0, 1, MODE_HOLD,       4'h0, 4'h0, 0, 4'h0, 0);
      step("tog1",      0, 0, 4'h0, 1, MODE_TOGGLE,     4'h5, 4'h5, 0, 4'h5, 0);
      step("tog2",      0, 0, 4'h0, 1, MODE_TOGGLE,     4'h5, 4'h0, 0, 4'h0, 0);
      step("tog3",      0, 0, 4'h0, 1, MODE_TOGGLE,     4'h5, 4'h5, 0, 4'h5, 0);
      step("tog_t0",    0, 0, 4'h0, 1, MODE_TOGGLE,     4'h0, 4'h5, 0, 4'h5, 0);
      step("tog_en0",   0, 0, 4'h0, 0, MODE_TOGGLE,     4'hF, 4'h5, 0, 4'h5, 0);
      step("ldE",       0, 1, 4'hE, 1, MODE_COUNT_UP,   4'h0, 4'hE, 0, 4'hE, 0);
      step("up1",       0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'hF, 0, 4'hF, 0);
      step("up_wrap",   0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'h0, 1, 4'hF, 1);
      step("up3",       0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'h1, 0, 4'hF, 1);
      step("ld1",       0, 1, 4'h1, 1, MODE_COUNT_DOWN, 4'h0, 4'h1, 0, 4'h1, 0);
      step("dn1",       0, 0, 4'h0, 1, MODE_COUNT_DOWN, 4'h0, 4'h0, 0, 4'h0, 0);
      step("dn_wrap",   0, 0, 4'h0, 1, MODE_COUNT_DOWN, 4'h0, 4'hF, 1, 4'h0, 1);
      step("dn3",       0, 0, 4'h0, 1, MODE_COUNT_DOWN, 4'h0, 4'hE, 0, 4'h0, 1);
      step("rev_up",    0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'hF, 0, 4'h1, 0);
      step("ld7",       0, 1, 4'h7, 1, MODE_COUNT_UP,   4'h0, 4'h7, 0, 4'h7, 0);
      step("ld_en0",    0, 1, 4'h3, 0, MODE_COUNT_UP,   4'h0, 4'h3, 0, 4'h3, 0);
      step("up_after",  0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'h4, 0, 4'h4, 0);
      step("ld5",       0, 1, 4'h5, 1, MODE_COUNT_UP,   4'h0, 4'h5, 0, 4'h5, 0);
      step("up6",       0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'h6, 0, 4'h6, 0);
      step("rst_ld",    1, 1, 4'hC, 1, MODE_COUNT_UP,   4'h0, 4'hA, 0, 4'hA, 0);
      step("resume1",   0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'hB, 0, 4'hB, 0);
      step("resume2",   0, 0, 4'h0, 1, MODE_COUNT_UP,   4'h0, 4'hC, 0, 4'hC, 0);
      step("en0_hold",  0, 0, 4'h0, 0, MODE_COUNT_UP,   4'h0, 4'hC, 0, 4'hC, 0);
      step("ldF",       0, 1, 4'hF, 1, MODE_COUNT_UP,   4'h0, 4'hF, 0, 4'hF, 0);
      step("en0_lim",   0, 0, 4'h0, 0, MODE_COUNT_UP,   4'h0, 4'hF, 0, 4'hF, 0);
      step("ld_tc",     0, 1, 4'hF, 1, MODE_COUNT_UP,   4'h0, 4'hF, 0, 4'hF, 0);
      @(negedge clk);
      en = 0; load = 0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d required=0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
